// File: rtl/eh2_dec_trigger_pipe.sv
// ---------------------------------------------------------------------------
// eh2_dec_trigger_pipe
//
// Purpose:
//   Consumes the decode-stage execute-trigger match vectors of both issue
//   slots (i0/i1). It applies per-thread trigger chaining, carries the
//   qualified matches down to commit (honouring stall and per-thread flush),
//   and at commit reports per-trigger hits, the resulting action (breakpoint
//   exception vs debug halt) and accumulated sticky hit bits to the TLU.
//
// Parameters:
//   NUM_THREADS  hardware threads (tid width TW = max(1, clog2(NUM_THREADS)))
//   PIPE_DEPTH   register stages from decode to commit, 1..4
//
// Ports:
//   clk, rst                     core clock, async active-high reset
//   dec_i{0,1}_valid_d           slot valid in decode
//   dec_i{0,1}_tid_d             slot thread id
//   dec_i{0,1}_trigger_match_d   raw per-trigger match vector
//   trig_chain                   per thread: [0] chains 0->1, [1] chains 2->3
//   trig_action                  per thread/trigger: 1 = halt, 0 = breakpoint
//   dec_stall                    freeze every stage
//   dec_flush                    per thread: kill in-flight entries
//   trig_hit_clr                 per thread/trigger sticky clear
//   i{0,1}_commit_*              commit-stage report (valid/tid/hit/brkpt/halt)
//   trig_hit_sticky              per thread/trigger accumulated hits
// ---------------------------------------------------------------------------

// Per-slot qualification and decode-to-commit shift pipeline.
module eh2_dec_trigger_slot #(
    parameter int NUM_THREADS = 2,
    parameter int PIPE_DEPTH  = 3,
    parameter int TW          = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        valid_i,
    input  logic [TW-1:0]               tid_i,
    input  logic [3:0]                  raw_i,
    input  logic [NUM_THREADS-1:0][1:0] chain_i,
    input  logic                        stall_i,
    input  logic [NUM_THREADS-1:0]      flush_i,
    output logic                        cm_vld_o,
    output logic [TW-1:0]               cm_tid_o,
    output logic [3:0]                  cm_q_o
);

    logic [3:0]                       q_dec;
    logic                             vld_dec;

    logic [PIPE_DEPTH-1:0]            vld_pipe_q, vld_pipe_d;
    logic [PIPE_DEPTH-1:0][TW-1:0]    tid_pipe_q, tid_pipe_d;
    logic [PIPE_DEPTH-1:0][3:0]       q_pipe_q,   q_pipe_d;

    // A chained pair only fires when both triggers of the pair match.
    always_comb begin
        q_dec = raw_i;
        if (chain_i[tid_i][0]) q_dec[1:0] = {2{raw_i[0] & raw_i[1]}};
        if (chain_i[tid_i][1]) q_dec[3:2] = {2{raw_i[2] & raw_i[3]}};
        if (!valid_i)          q_dec      = '0;
        vld_dec = valid_i & (|q_dec);
    end

    always_comb begin
        vld_pipe_d = vld_pipe_q;
        tid_pipe_d = tid_pipe_q;
        q_pipe_d   = q_pipe_q;
        if (!stall_i) begin
            vld_pipe_d[0] = vld_dec;
            tid_pipe_d[0] = tid_i;
            q_pipe_d[0]   = q_dec;
            for (int s = 1; s < PIPE_DEPTH; s++) begin
                vld_pipe_d[s] = vld_pipe_q[s-1];
                tid_pipe_d[s] = tid_pipe_q[s-1];
                q_pipe_d[s]   = q_pipe_q[s-1];
            end
        end
        // Flush is applied to the post-shift/hold view, so it also blocks
        // capture of a decode entry of the flushed thread and works under stall.
        for (int s = 0; s < PIPE_DEPTH; s++) begin
            if (flush_i[tid_pipe_d[s]]) vld_pipe_d[s] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_q <= '0;
            tid_pipe_q <= '0;
            q_pipe_q   <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            tid_pipe_q <= tid_pipe_d;
            q_pipe_q   <= q_pipe_d;
        end
    end

    assign cm_vld_o = vld_pipe_q[PIPE_DEPTH-1];
    assign cm_tid_o = tid_pipe_q[PIPE_DEPTH-1];
    assign cm_q_o   = q_pipe_q[PIPE_DEPTH-1];

endmodule

module eh2_dec_trigger_pipe #(
    parameter int NUM_THREADS = 2,
    parameter int PIPE_DEPTH  = 3,
    localparam int TW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       dec_i0_valid_d,
    input  logic                       dec_i1_valid_d,
    input  logic [TW-1:0]              dec_i0_tid_d,
    input  logic [TW-1:0]              dec_i1_tid_d,
    input  logic [3:0]                 dec_i0_trigger_match_d,
    input  logic [3:0]                 dec_i1_trigger_match_d,
    input  logic [NUM_THREADS*2-1:0]   trig_chain,
    input  logic [NUM_THREADS*4-1:0]   trig_action,
    input  logic                       dec_stall,
    input  logic [NUM_THREADS-1:0]     dec_flush,
    input  logic [NUM_THREADS*4-1:0]   trig_hit_clr,
    output logic                       i0_commit_valid,
    output logic                       i1_commit_valid,
    output logic [TW-1:0]              i0_commit_tid,
    output logic [TW-1:0]              i1_commit_tid,
    output logic [3:0]                 i0_commit_hit,
    output logic [3:0]                 i1_commit_hit,
    output logic                       i0_commit_brkpt,
    output logic                       i1_commit_brkpt,
    output logic                       i0_commit_halt,
    output logic                       i1_commit_halt,
    output logic [NUM_THREADS*4-1:0]   trig_hit_sticky
);

    // Per-thread views of the flat configuration buses.
    logic [NUM_THREADS-1:0][1:0] chain_t;
    logic [NUM_THREADS-1:0][3:0] act_t;
    logic [NUM_THREADS-1:0][3:0] clr_t;

    assign chain_t = trig_chain;
    assign act_t   = trig_action;
    assign clr_t   = trig_hit_clr;

    logic [1:0]          in_vld;
    logic [1:0][TW-1:0]  in_tid;
    logic [1:0][3:0]     in_raw;
    logic [1:0]          cm_vld;
    logic [1:0][TW-1:0]  cm_tid;
    logic [1:0][3:0]     cm_q;

    assign in_vld = {dec_i1_valid_d, dec_i0_valid_d};
    assign in_tid = {dec_i1_tid_d, dec_i0_tid_d};
    assign in_raw = {dec_i1_trigger_match_d, dec_i0_trigger_match_d};

    for (genvar n = 0; n < 2; n++) begin : g_slot
        eh2_dec_trigger_slot #(
            .NUM_THREADS (NUM_THREADS),
            .PIPE_DEPTH  (PIPE_DEPTH),
            .TW          (TW)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .valid_i  (in_vld[n]),
            .tid_i    (in_tid[n]),
            .raw_i    (in_raw[n]),
            .chain_i  (chain_t),
            .stall_i  (dec_stall),
            .flush_i  (dec_flush),
            .cm_vld_o (cm_vld[n]),
            .cm_tid_o (cm_tid[n]),
            .cm_q_o   (cm_q[n])
        );
    end

    logic                        kill_i1;
    logic [1:0]                  rep_vld;
    logic [1:0][TW-1:0]          rep_tid;
    logic [1:0][3:0]             rep_hit;
    logic [1:0]                  rep_brk;
    logic [1:0]                  rep_hlt;
    logic [NUM_THREADS-1:0][3:0] sticky_set;
    logic [NUM_THREADS-1:0][3:0] sticky_q, sticky_d;

    always_comb begin
        // i0's trap kills the younger i1 of the same thread.
        kill_i1 = cm_vld[0] & cm_vld[1] & (cm_tid[0] == cm_tid[1]);
        rep_vld = cm_vld;
        if (kill_i1) rep_vld[1] = 1'b0;
        for (int n = 0; n < 2; n++) begin
            rep_hit[n] = rep_vld[n] ? cm_q[n]   : '0;
            rep_tid[n] = rep_vld[n] ? cm_tid[n] : '0;
            // Action is looked up at commit so late config changes take effect.
            rep_brk[n] = |(rep_hit[n] & ~act_t[rep_tid[n]]);
            rep_hlt[n] = |(rep_hit[n] &  act_t[rep_tid[n]]);
        end
    end

    always_comb begin
        sticky_set = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            for (int n = 0; n < 2; n++) begin
                if (rep_vld[n] && (rep_tid[n] == TW'(t))) sticky_set[t] |= rep_hit[n];
            end
        end
        // Set wins over a simultaneous clear.
        sticky_d = (sticky_q & ~clr_t) | sticky_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sticky_q <= '0;
        else     sticky_q <= sticky_d;
    end

    assign i0_commit_valid = rep_vld[0];
    assign i1_commit_valid = rep_vld[1];
    assign i0_commit_tid   = rep_tid[0];
    assign i1_commit_tid   = rep_tid[1];
    assign i0_commit_hit   = rep_hit[0];
    assign i1_commit_hit   = rep_hit[1];
    assign i0_commit_brkpt = rep_brk[0];
    assign i1_commit_brkpt = rep_brk[1];
    assign i0_commit_halt  = rep_hlt[0];
    assign i1_commit_halt  = rep_hlt[1];
    assign trig_hit_sticky = sticky_q;

endmodule

// File: tb/tb_eh2_dec_trigger_pipe.sv
// ---------------------------------------------------------------------------
// tb_eh2_dec_trigger_pipe
//
// Directed bench for eh2_dec_trigger_pipe (NUM_THREADS=2, PIPE_DEPTH=3).
// Inputs change and outputs are sampled on the falling clock edge; each
// step() advances exactly one rising edge.
// ---------------------------------------------------------------------------
module tb_eh2_dec_trigger_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       i0_v, i1_v;
    logic [0:0] i0_t, i1_t;
    logic [3:0] i0_r, i1_r;
    logic [3:0] chain;
    logic [7:0] action;
    logic       stall;
    logic [1:0] flush;
    logic [7:0] clr;

    logic       o0_v, o1_v;
    logic [0:0] o0_t, o1_t;
    logic [3:0] o0_h, o1_h;
    logic       o0_b, o1_b, o0_x, o1_x;
    logic [7:0] sticky;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    eh2_dec_trigger_pipe #(.NUM_THREADS(2), .PIPE_DEPTH(3)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .dec_i0_valid_d         (i0_v),
        .dec_i1_valid_d         (i1_v),
        .dec_i0_tid_d           (i0_t),
        .dec_i1_tid_d           (i1_t),
        .dec_i0_trigger_match_d (i0_r),
        .dec_i1_trigger_match_d (i1_r),
        .trig_chain             (chain),
        .trig_action            (action),
        .dec_stall              (stall),
        .dec_flush              (flush),
        .trig_hit_clr           (clr),
        .i0_commit_valid        (o0_v),
        .i1_commit_valid        (o1_v),
        .i0_commit_tid          (o0_t),
        .i1_commit_tid          (o1_t),
        .i0_commit_hit          (o0_h),
        .i1_commit_hit          (o1_h),
        .i0_commit_brkpt        (o0_b),
        .i1_commit_brkpt        (o1_b),
        .i0_commit_halt         (o0_x),
        .i1_commit_halt         (o1_x),
        .trig_hit_sticky        (sticky)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk0(input string tag, input logic v, input logic t, input logic [3:0] h,
                        input logic b, input logic x);
        chk({tag, ".i0_valid"}, {7'd0, o0_v}, {7'd0, v});
        chk({tag, ".i0_tid"},   {7'd0, o0_t}, {7'd0, t});
        chk({tag, ".i0_hit"},   {4'd0, o0_h}, {4'd0, h});
        chk({tag, ".i0_brkpt"}, {7'd0, o0_b}, {7'd0, b});
        chk({tag, ".i0_halt"},  {7'd0, o0_x}, {7'd0, x});
    endtask

    task automatic chk1(input string tag, input logic v, input logic t, input logic [3:0] h,
                        input logic b, input logic x);
        chk({tag, ".i1_valid"}, {7'd0, o1_v}, {7'd0, v});
        chk({tag, ".i1_tid"},   {7'd0, o1_t}, {7'd0, t});
        chk({tag, ".i1_hit"},   {4'd0, o1_h}, {4'd0, h});
        chk({tag, ".i1_brkpt"}, {7'd0, o1_b}, {7'd0, b});
        chk({tag, ".i1_halt"},  {7'd0, o1_x}, {7'd0, x});
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle();
        i0_v = 0; i1_v = 0; i0_t = 0; i1_t = 0; i0_r = 0; i1_r = 0;
    endtask

    task automatic clear_sticky();
        clr = 8'hFF; step(1); clr = 8'h00;
    endtask

    initial begin
        rst = 1; idle(); chain = 0; action = 0; stall = 0; flush = 0; clr = 0;

        // Reset state, during and the cycle after release.
        step(2);
        chk0("rst", 0, 0, 4'h0, 0, 0); chk1("rst", 0, 0, 4'h0, 0, 0);
        chk("rst.sticky", sticky, 8'h00);
        rst = 0; step(1);
        chk0("post_rst", 0, 0, 4'h0, 0, 0); chk1("post_rst", 0, 0, 4'h0, 0, 0);

        // Unchained hit, exactly 3 cycles latency.
        i0_v = 1; i0_t = 0; i0_r = 4'b0001; step(1); idle();
        step(1); chk("unch.early", {7'd0, o0_v}, 8'h00);
        step(1); chk0("unch", 1, 0, 4'b0001, 1, 0); chk1("unch", 0, 0, 4'h0, 0, 0);
        step(1); chk("unch.sticky", sticky, 8'h01); chk("unch.drain", {7'd0, o0_v}, 8'h00);
        clr = 8'h0F; step(1); clr = 0; chk("clr_nohit", sticky, 8'h00);

        // Chaining 0->1 on thread 0.
        chain = 4'b0001;
        i0_v = 1; i0_t = 0; i0_r = 4'b0001; step(1); idle(); step(2);
        chk0("chain_half", 0, 0, 4'h0, 0, 0);
        step(1); chk("chain_half.sticky", sticky, 8'h00);
        i0_v = 1; i0_t = 0; i0_r = 4'b0011; step(1); idle(); step(2);
        chk0("chain_full", 1, 0, 4'b0011, 1, 0);
        step(1); chk("chain_full.sticky", sticky, 8'h03); clear_sticky();

        // Chain 2->3 on thread 1 only: thread 0 unaffected.
        chain = 4'b1000;
        i0_v = 1; i0_t = 0; i0_r = 4'b0100; i1_v = 1; i1_t = 1; i1_r = 4'b0100;
        step(1); idle(); step(2);
        chk0("chain_thr", 1, 0, 4'b0100, 1, 0); chk1("chain_thr", 0, 0, 4'h0, 0, 0);
        step(1); chk("chain_thr.sticky", sticky, 8'h04); clear_sticky();
        chain = 0;

        // Stall 4 cycles, plus a decode entry offered during stall is dropped.
        i0_v = 1; i0_t = 1; i0_r = 4'b0010; step(1);
        i0_t = 0; i0_r = 4'b1000; stall = 1; step(1); idle(); step(3);
        chk("stall.hold", {7'd0, o0_v}, 8'h00);
        stall = 0; step(1); chk("stall.e6", {7'd0, o0_v}, 8'h00);
        step(1); chk0("stall", 1, 1, 4'b0010, 1, 0);
        stall = 1; step(1); chk0("stall.commit_hold", 1, 1, 4'b0010, 1, 0);
        stall = 0; step(1); chk("stall.drain", {7'd0, o0_v}, 8'h00);
        step(3); chk("stall.no_extra", {7'd0, o0_v}, 8'h00);
        chk("stall.sticky", sticky, 8'h20); clear_sticky();

        // Flush thread 1 mid-flight; thread 0 entry still commits.
        i0_v = 1; i0_t = 1; i0_r = 4'b0001; i1_v = 1; i1_t = 0; i1_r = 4'b0010;
        step(1); idle(); step(1);
        flush = 2'b10; step(1); flush = 0;
        chk0("flush", 0, 0, 4'h0, 0, 0); chk1("flush", 1, 0, 4'b0010, 1, 0);
        step(1); chk("flush.sticky", sticky, 8'h02); clear_sticky();

        // Flush blocks capture of a decode entry of the flushed thread.
        i0_v = 1; i0_t = 0; i0_r = 4'b0001; i1_v = 1; i1_t = 1; i1_r = 4'b0001;
        flush = 2'b01; step(1); flush = 0; idle(); step(2);
        chk0("flush_dec", 0, 0, 4'h0, 0, 0); chk1("flush_dec", 1, 1, 4'b0001, 1, 0);
        step(1); chk("flush_dec.sticky", sticky, 8'h10); clear_sticky();

        // Slot ordering, same thread: i1 suppressed.
        action = 8'h04;
        i0_v = 1; i0_t = 0; i0_r = 4'b0100; i1_v = 1; i1_t = 0; i1_r = 4'b1000;
        step(1); idle(); step(2);
        chk0("order_same", 1, 0, 4'b0100, 0, 1); chk1("order_same", 0, 0, 4'h0, 0, 0);
        step(1); chk("order_same.sticky", sticky, 8'h04); clear_sticky();

        // Different threads: both report.
        i0_v = 1; i0_t = 0; i0_r = 4'b0100; i1_v = 1; i1_t = 1; i1_r = 4'b1000;
        step(1); idle(); step(2);
        chk0("order_diff", 1, 0, 4'b0100, 0, 1); chk1("order_diff", 1, 1, 4'b1000, 1, 0);
        step(1); chk("order_diff.sticky", sticky, 8'h84); clear_sticky();

        // Action sampled at commit, not decode.
        action = 8'h00;
        i0_v = 1; i0_t = 0; i0_r = 4'b0001; step(1); idle(); action = 8'h01; step(2);
        chk0("act_late", 1, 0, 4'b0001, 0, 1);
        step(1); clear_sticky(); action = 0;

        // Set wins over clear; then clear without hit.
        i0_v = 1; i0_t = 0; i0_r = 4'b0001; step(1); idle(); step(2);
        chk("contend.hit", {4'd0, o0_h}, 8'h01);
        clr = 8'h01; step(1); chk("contend.set_wins", sticky, 8'h01);
        step(1); clr = 0; chk("contend.clear", sticky, 8'h00);

        // Reset with three entries in flight.
        i0_v = 1; i0_t = 0; i0_r = 4'b0001; step(3); idle();
        chk("rst_mid.pre", {7'd0, o0_v}, 8'h01);
        rst = 1; #1;
        chk0("rst_mid", 0, 0, 4'h0, 0, 0); chk("rst_mid.sticky", sticky, 8'h00);
        step(1); rst = 0;
        step(1); chk0("rst_mid.after1", 0, 0, 4'h0, 0, 0);
        step(1); chk0("rst_mid.after2", 0, 0, 4'h0, 0, 0);
        step(1); chk0("rst_mid.after3", 0, 0, 4'h0, 0, 0);
        chk("rst_mid.sticky_after", sticky, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
